fp_addsub_pipe: RTL
===================

# fp_addsub_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. It is the next generation of the team's single-precision `floating_1` adder and adds:
- generic exponent/mantissa widths;
- a per-operation add/subtract mode;
- valid/ready flow control with backpressure;
- defined special-value handling.

It sits between operand producers (FFT butterflies, accumulators) and result consumers, and accepts one operation per cycle.

## Interface
- `EXP_W`, default 8: exponent field width (≥3).
- `MAN_W`, default 23: stored fraction width, hidden bit excluded (≥2). Word width `W = 1+EXP_W+MAN_W`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept this cycle.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `sub`  in  1  0: A+B; 1: A−B (B sign inverted at entry).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `c`  out  W  result.
- `flags`  out  4  {invalid, overflow, underflow, inexact} aligned with `c`.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Global advance `adv = !out_valid || out_ready`. `in_ready = adv`.
- All stage registers load only when `adv` is high. A stage valid bit propagates even for bubbles.
- Stage S1 (unpack):
  - classify zero / normal / inf / NaN;
  - subnormal inputs are flushed to signed zero;
  - apply `sub`;
  - swap so `|X| ≥ |Y|` (compare exponent, then fraction).
- Stage S2 (align): shift Y's significand right by `eX−eY`, keeping guard, round and sticky bits. A shift ≥ `MAN_W+3` leaves Y as sticky only.
- Stage S3 (add): effective add/subtract on `MAN_W+4`-bit significands plus carry; leading-zero count on the result.
- Stage S4 (normalise/round/pack):
  - shift left by LZC or right by 1 on carry, adjusting the exponent;
  - round per Configuration; re-normalise on rounding carry.
- Result rules:
  - Exact zero from cancellation is +0. (−0)+(−0) is −0.
  - Exponent ≥ all-ones gives ±inf with overflow=1 and inexact=1.
  - Exponent ≤ 0 after normalisation gives signed zero with underflow=1, plus inexact=1 if nonzero bits were lost.
- Special values:
  - Any NaN input gives canonical quiet NaN (sign 0, exponent all-ones, fraction MSB 1, rest 0).
  - inf − inf gives canonical NaN with invalid=1.
  - inf ± finite gives that inf.
- The sign of the result comes from the larger-magnitude operand after the swap.

## Timing
- Latency: exactly 4 cycles from input transfer to `out_valid`, with no stall. Throughput: 1 per cycle.
- Under `out_ready=0` with `out_valid=1`, the whole pipeline freezes: `c`, `flags` and `out_valid` are held stable, and `in_ready=0` the same cycle (combinational from `out_ready`).
- No result is dropped or duplicated. Input accepted in cycle t with no stalls appears in cycle t+4.
- Reset, asynchronous and effective immediately:
  - all stage valids = 0, `out_valid = 0`;
  - `c = 0`, `flags = 0`;
  - `in_ready` = 1 after reset because `out_valid = 0`.
- Reset mid-operation discards all in-flight operations. The first input after `rst_n` rises is accepted on the next rising edge.
- Data registers carry don't-care contents when their valid bit is 0. `c` is meaningful only when `out_valid=1`.

## Configuration
- Macro `FP_ADDSUB_RNE_EN`.
- Defined: round-to-nearest-even using guard/round/sticky. Inexact=1 when any of guard/round/sticky is nonzero.
- Undefined: truncation toward zero (guard/round/sticky discarded). Inexact is still reported. Overflow saturates to the largest finite value with overflow=1 instead of inf.
- Latency is identical in both builds.

## Test plan
- Default params, `a=414c0000` (12.75), `b=42460000` (49.5), `sub=0`, `out_ready=1` → `c=42790000` (62.25), `flags=0`, exactly 4 cycles after acceptance.
- Same operands, `a=42460000`, `b=414c0000`, `sub=1` → `c=42130000` (36.75). `a=3f800000`, `b=3f800000`, `sub=1` → `c=00000000`.
- Rounding: `3f800000 + 33800000` → `3f800000`, inexact=1 (tie to even). `3f800000 + 34400000` → `3f800002` with `FP_ADDSUB_RNE_EN`, `3f800001` without.
- Specials: `7f800000 + ff800000` → `7fc00000`, invalid=1. `7fc00001 + 3f800000` → `7fc00000`. `7f7fffff + 7f7fffff` → `7f800000`, overflow=1 (RNE build).
- Backpressure: stream 10 back-to-back operations, hold `out_ready=0` for 3 cycles mid-stream → `c` held stable, `in_ready=0` during the hold, all 10 results emitted in order with none lost. Assert `rst_n=0` with 3 in flight → `out_valid=0` immediately, no stale results after release.
- Param sweep `EXP_W=5`, `MAN_W=10` (half precision): `3c00+3c00` → `4000`, `7bff+7bff` → `7c00` with overflow=1.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with generic EXP_W/MAN_W.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise truncate and saturate on overflow.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] c,
  output logic [3:0]           flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;
  localparam int LZW = $clog2(SW + 2);
  localparam int XW  = EXP_W + LZW + 1;
  localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [XW-1:0] EMAX = XW'({EXP_W{1'b1}});

  // Valid/ready: a transfer occurs on a rising edge where valid && ready. Every stage
  // advances together when the output register is empty or being drained, so in_ready
  // follows out_ready combinationally and a stalled result stays frozen on c/flags.
  logic adv;
  logic out_valid_q;
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, any_nan, inf_clash, swap;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb;
  assign sa        = a[W-1];
  assign sb        = b[W-1] ^ sub;
  assign ea        = a[W-2:MAN_W];
  assign eb        = b[W-2:MAN_W];
  assign fa        = a[MAN_W-1:0];
  assign fb        = b[MAN_W-1:0];
  assign a_zero    = (ea == '0);
  assign b_zero    = (eb == '0);
  assign a_inf     = (&ea) && (fa == '0);
  assign b_inf     = (&eb) && (fb == '0);
  assign a_nan     = (&ea) && (fa != '0);
  assign b_nan     = (&eb) && (fb != '0);
  assign any_nan   = a_nan | b_nan;
  assign inf_clash = a_inf & b_inf & (sa ^ sb);
  // Subnormals are flushed by dropping the hidden bit and fraction together.
  assign ma        = a_zero ? '0 : {1'b1, fa};
  assign mb        = b_zero ? '0 : {1'b1, fb};
  assign swap      = {eb, b_zero ? '0 : fb} > {ea, a_zero ? '0 : fa};

  logic             s1_v_q, s1_sx_q, s1_sy_q, s1_spec_q, s1_inv_q;
  logic [EXP_W-1:0] s1_ex_q, s1_ey_q;
  logic [MAN_W:0]   s1_mx_q, s1_my_q;
  logic [W-1:0]     s1_sval_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0; s1_sx_q <= 1'b0; s1_sy_q <= 1'b0; s1_spec_q <= 1'b0; s1_inv_q <= 1'b0;
      s1_ex_q <= '0; s1_ey_q <= '0; s1_mx_q <= '0; s1_my_q <= '0; s1_sval_q <= '0;
    end else if (adv) begin
      s1_v_q    <= in_valid;
      s1_sx_q   <= swap ? sb : sa;
      s1_sy_q   <= swap ? sa : sb;
      s1_ex_q   <= swap ? eb : ea;
      s1_ey_q   <= swap ? ea : eb;
      s1_mx_q   <= swap ? mb : ma;
      s1_my_q   <= swap ? ma : mb;
      s1_spec_q <= any_nan | a_inf | b_inf;
      s1_inv_q  <= inf_clash & ~any_nan;
      s1_sval_q <= (any_nan | inf_clash) ? QNAN : {swap ? sb : sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic [EXP_W-1:0] d;
  logic [2*SW-1:0]  wide;
  logic [SW-1:0]    al_d;
  assign d    = s1_ex_q - s1_ey_q;
  assign wide = {s1_my_q, 3'b000, {SW{1'b0}}} >> d;
  always_comb begin
    if (32'(d) >= 32'(MAN_W + 3)) al_d = {{(SW-1){1'b0}}, |s1_my_q};
    else                          al_d = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
  end

  logic             s2_v_q, s2_sx_q, s2_esub_q, s2_zs_q, s2_spec_q, s2_inv_q;
  logic [EXP_W-1:0] s2_ex_q;
  logic [SW-1:0]    s2_mx_q, s2_my_q;
  logic [W-1:0]     s2_sval_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0; s2_sx_q <= 1'b0; s2_esub_q <= 1'b0; s2_zs_q <= 1'b0; s2_spec_q <= 1'b0;
      s2_inv_q <= 1'b0; s2_ex_q <= '0; s2_mx_q <= '0; s2_my_q <= '0; s2_sval_q <= '0;
    end else if (adv) begin
      s2_v_q    <= s1_v_q;
      s2_sx_q   <= s1_sx_q;
      s2_esub_q <= s1_sx_q ^ s1_sy_q;
      s2_zs_q   <= s1_sx_q & s1_sy_q;
      s2_ex_q   <= s1_ex_q;
      s2_mx_q   <= {s1_mx_q, 3'b000};
      s2_my_q   <= al_d;
      s2_spec_q <= s1_spec_q;
      s2_inv_q  <= s1_inv_q;
      s2_sval_q <= s1_sval_q;
    end
  end

  function automatic logic [LZW-1:0] lzc(input logic [SW:0] v);
    lzc = LZW'(SW + 1);
    for (int i = 0; i <= SW; i++) if (v[i]) lzc = LZW'(SW - i);
  endfunction

  logic [SW:0] sum_d;
  assign sum_d = s2_esub_q ? ({1'b0, s2_mx_q} - {1'b0, s2_my_q})
                           : ({1'b0, s2_mx_q} + {1'b0, s2_my_q});

  logic             s3_v_q, s3_sx_q, s3_zs_q, s3_spec_q, s3_inv_q;
  logic [EXP_W-1:0] s3_ex_q;
  logic [SW:0]      s3_sum_q;
  logic [LZW-1:0]   s3_lz_q;
  logic [W-1:0]     s3_sval_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v_q <= 1'b0; s3_sx_q <= 1'b0; s3_zs_q <= 1'b0; s3_spec_q <= 1'b0; s3_inv_q <= 1'b0;
      s3_ex_q <= '0; s3_sum_q <= '0; s3_lz_q <= '0; s3_sval_q <= '0;
    end else if (adv) begin
      s3_v_q    <= s2_v_q;
      s3_sx_q   <= s2_sx_q;
      s3_zs_q   <= s2_zs_q;
      s3_ex_q   <= s2_ex_q;
      s3_sum_q  <= sum_d;
      s3_lz_q   <= lzc(sum_d);
      s3_spec_q <= s2_spec_q;
      s3_inv_q  <= s2_inv_q;
      s3_sval_q <= s2_sval_q;
    end
  end

  logic [SW-1:0]    norm;
  logic [XW-1:0]    en, er;
  logic             rup, inexact;
  logic [MAN_W+1:0] rm;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     c_d;
  logic [3:0]       flags_d;
  always_comb begin
    // The hidden bit normally sits at SW-1, one below the carry position.
    if (s3_sum_q[SW]) begin
      norm = {s3_sum_q[SW:2], |s3_sum_q[1:0]};
      en   = XW'(s3_ex_q) + XW'(1);
    end else begin
      norm = s3_sum_q[SW-1:0] << (s3_lz_q - LZW'(1));
      en   = XW'(s3_ex_q) - XW'(s3_lz_q) + XW'(1);
    end
    inexact = |norm[2:0];
`ifdef FP_ADDSUB_RNE_EN
    rup = norm[2] & (norm[3] | norm[1] | norm[0]);
`else
    rup = 1'b0;
`endif
    rm      = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rup);
    frac    = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
    er      = en + XW'(rm[MAN_W+1]);
    c_d     = {s3_sx_q, er[EXP_W-1:0], frac};
    flags_d = {3'b000, inexact};
    if (s3_spec_q) begin
      c_d     = s3_sval_q;
      flags_d = {s3_inv_q, 3'b000};
    end else if (s3_sum_q == '0) begin
      c_d     = {s3_zs_q, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (en[XW-1] || en == '0) begin
      c_d     = {s3_sx_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else if (er >= EMAX) begin
`ifdef FP_ADDSUB_RNE_EN
      c_d     = {s3_sx_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
      c_d     = {s3_sx_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
      flags_d = 4'b0101;
    end
  end

  logic [W-1:0] c_q;
  logic [3:0]   flags_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      out_valid_q <= s3_v_q;
      c_q         <= c_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign flags     = flags_q;
endmodule
